// File: rtl/muldiv_hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_pkg
// Description : Shared definitions for the HI/LO multiply/divide front end.
//               Op-code encodings, FSM state encoding, multiply-kind tag and
//               small decode helpers.
// Revision    : 1.0  initial release
// ============================================================================
package muldiv_hilo_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_HILO_W = 64;

  // Operation codes presented on op_code.
  typedef enum logic [3:0] {
    MC_MULT  = 4'd0,
    MC_MULTU = 4'd1,
    MC_MADD  = 4'd2,
    MC_MADDU = 4'd3,
    MC_MSUB  = 4'd4,
    MC_MSUBU = 4'd5,
    MC_DIV   = 4'd6,
    MC_DIVU  = 4'd7,
    MC_MTHI  = 4'd8,
    MC_MTLO  = 4'd9,
    MC_MFHI  = 4'd10,
    MC_MFLO  = 4'd11,
    MC_NONE  = 4'd15
  } op_code_e;

  // Front-end sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL1     = 2'd1,
    ST_MUL2     = 2'd2,
    ST_DIV_WAIT = 2'd3
  } state_e;

  // How the multiply product is combined with HI:LO at writeback.
  typedef enum logic [1:0] {
    MK_MULT = 2'd0,
    MK_MADD = 2'd1,
    MK_MSUB = 2'd2
  } mul_kind_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MC_MULT)  || (op == MC_MULTU) ||
           (op == MC_MADD)  || (op == MC_MADDU) ||
           (op == MC_MSUB)  || (op == MC_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MC_DIV) || (op == MC_DIVU);
  endfunction

  // Signed product for the non-U multiply variants.
  function automatic logic mul_is_signed(input logic [3:0] op);
    return (op == MC_MULT) || (op == MC_MADD) || (op == MC_MSUB);
  endfunction

  function automatic mul_kind_e mul_kind_of(input logic [3:0] op);
    mul_kind_e kind;
    kind = MK_MULT;
    if ((op == MC_MADD) || (op == MC_MADDU)) kind = MK_MADD;
    if ((op == MC_MSUB) || (op == MC_MSUBU)) kind = MK_MSUB;
    return kind;
  endfunction

endpackage : muldiv_hilo_pkg
`default_nettype wire

// File: rtl/muldiv_hilo_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_if
// Description : Bundle between the execute stage / divider and the HI/LO
//               front end.
//   op_valid/op_code/op_a/op_b : instruction presented this cycle
//   result                     : MFHI/MFLO read data, 0 otherwise
//   stall                      : hold the current instruction
//   div_start_s/div_start_u    : one-cycle divide start pulses
//   div_dividend/div_divisor   : divider operands (op_a / op_b)
//   div_quotient/div_remainder : divider results
//   div_stall                  : divider busy
//   slave  : the muldiv_hilo block
//   master : the surrounding pipeline and divider
// Revision    : 1.0  initial release
// ============================================================================
interface muldiv_hilo_if;

  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        stall;
  logic        div_start_s;
  logic        div_start_u;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_stall;

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    input  div_quotient, div_remainder, div_stall,
    output result, stall,
    output div_start_s, div_start_u, div_dividend, div_divisor
  );

  modport master (
    output op_valid, op_code, op_a, op_b,
    output div_quotient, div_remainder, div_stall,
    input  result, stall,
    input  div_start_s, div_start_u, div_dividend, div_divisor
  );

endinterface : muldiv_hilo_if
`default_nettype wire

// File: rtl/muldiv_hilo_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe
// Description : Two-stage 33x33 signed multiplier with an operation tag
//               travelling alongside the data.
//   Stage 1 registers the operands, extended to 33 bits (sign- or
//   zero-extended by i_signed) so one signed multiplier serves both flavours.
//   Stage 2 registers the low 64 bits of the product and the tag.
//   clock, reset        : clock, asynchronous active-high reset
//   i_valid/i_signed    : launch a multiply / signed operand extension
//   i_kind              : writeback tag (MULT / MADD / MSUB)
//   i_a, i_b            : 32-bit operands
//   o_valid/o_kind      : stage-2 valid and tag
//   o_product           : 64-bit product
// Revision    : 1.0  initial release
// ============================================================================
module mult_pipe
  import muldiv_hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_signed,
  input  mul_kind_e   i_kind,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  output mul_kind_e   o_kind,
  output logic [63:0] o_product
);

  logic        r_v1;
  mul_kind_e   r_kind1;
  logic [32:0] r_a1;
  logic [32:0] r_b1;

  logic        r_v2;
  mul_kind_e   r_kind2;
  logic [63:0] r_prod2;

  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;

  // The 33-bit operands are sign-extended to 64 bits; the low 64 bits of an
  // unsigned 64x64 multiply then equal the signed 33x33 product exactly.
  assign w_a_ext = {{31{r_a1[32]}}, r_a1};
  assign w_b_ext = {{31{r_b1[32]}}, r_b1};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_kind1 <= MK_MULT;
      r_a1    <= '0;
      r_b1    <= '0;
      r_v2    <= 1'b0;
      r_kind2 <= MK_MULT;
      r_prod2 <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_kind1 <= i_kind;
        r_a1    <= {i_signed & i_a[31], i_a};
        r_b1    <= {i_signed & i_b[31], i_b};
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_kind2 <= r_kind1;
        r_prod2 <= w_prod;
      end
    end
  end

  assign o_valid   = r_v2;
  assign o_kind    = r_kind2;
  assign o_product = r_prod2;

endmodule : mult_pipe
`default_nettype wire

// File: rtl/muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo
// Description : MIPS32 execute-stage multiply/divide front end and HI/LO
//               register file. Multiplies run through mult_pipe and are
//               written back (plain, accumulate or subtract) when the FSM is
//               in MUL2. Divides are launched on the external divider and its
//               quotient/remainder are captured into LO/HI once it drops
//               div_stall. Any instruction is held while HI/LO are pending.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : muldiv_hilo_if.slave (instruction, result, stall, divider)
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_hilo
  import muldiv_hilo_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  muldiv_hilo_if.slave bus
);

  state_e      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_stall;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_mul_launch;
  logic        w_mul_signed;
  mul_kind_e   w_mul_kind_in;

  logic        w_mul_valid;
  mul_kind_e   w_mul_kind;
  logic [63:0] w_product;
  logic [63:0] w_hilo;
  logic [63:0] w_hilo_next;
  logic [31:0] w_result;

  // Every op code waits while anything is in flight, including MT/MF, so
  // MT/MF only ever execute against settled HI/LO.
  assign w_stall  = bus.op_valid && (r_state != ST_IDLE);
  assign w_accept = bus.op_valid && !w_stall;

  assign w_is_mul      = is_mul_op(bus.op_code);
  assign w_is_div      = is_div_op(bus.op_code);
  assign w_mul_launch  = w_accept && w_is_mul;
  assign w_mul_signed  = mul_is_signed(bus.op_code);
  assign w_mul_kind_in = mul_kind_of(bus.op_code);

  mult_pipe u_mult_pipe (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (w_mul_launch),
    .i_signed  (w_mul_signed),
    .i_kind    (w_mul_kind_in),
    .i_a       (bus.op_a),
    .i_b       (bus.op_b),
    .o_valid   (w_mul_valid),
    .o_kind    (w_mul_kind),
    .o_product (w_product)
  );

  // Writeback value; add/subtract wrap modulo 2^64.
  assign w_hilo = {r_hi, r_lo};

  always_comb begin
    w_hilo_next = w_product;
    case (w_mul_kind)
      MK_MADD: w_hilo_next = w_hilo + w_product;
      MK_MSUB: w_hilo_next = w_hilo - w_product;
      default: w_hilo_next = w_product;
    endcase
  end

  // MF read data is combinational in the accept cycle; zero otherwise.
  always_comb begin
    w_result = '0;
    if (w_accept && (bus.op_code == MC_MFHI)) w_result = r_hi;
    if (w_accept && (bus.op_code == MC_MFLO)) w_result = r_lo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= ST_MUL1;
            end else if (w_is_div) begin
              r_state <= ST_DIV_WAIT;
            end else if (bus.op_code == MC_MTHI) begin
              r_hi <= bus.op_a;
            end else if (bus.op_code == MC_MTLO) begin
              r_lo <= bus.op_a;
            end
          end
        end
        ST_MUL1: begin
          r_state <= ST_MUL2;
        end
        ST_MUL2: begin
          if (w_mul_valid) begin
            {r_hi, r_lo} <= w_hilo_next;
          end
          r_state <= ST_IDLE;
        end
        ST_DIV_WAIT: begin
          // div_stall only matters here; whatever the divider presents on
          // its first idle cycle (including divide-by-zero) is taken as is.
          if (!bus.div_stall) begin
            r_lo    <= bus.div_quotient;
            r_hi    <= bus.div_remainder;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stall        = w_stall;
  assign bus.result       = w_result;
  assign bus.div_start_s  = w_accept && (bus.op_code == MC_DIV);
  assign bus.div_start_u  = w_accept && (bus.op_code == MC_DIVU);
  assign bus.div_dividend = bus.op_a;
  assign bus.div_divisor  = bus.op_b;

endmodule : muldiv_hilo
`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_hilo
// Description : Self-checking bench for muldiv_hilo. Contains a behavioural
//               32-cycle divider and a HI:LO reference model computed with
//               plain 64-bit arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  muldiv_hilo_if bus ();

  muldiv_hilo dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference divide: truncating division, divide-by-zero gives q=all ones,
  // r=dividend. Returns {remainder, quotient}.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Behavioural divider: busy for 32 cycles after a start, results held
  // through reset (only its control state is reset).
  int          dm_cnt;
  logic        dm_stall;
  logic [31:0] dm_q, dm_r;
  logic        force_en, force_stall;
  logic [63:0] dm_res;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dm_cnt   <= 0;
      dm_stall <= 1'b0;
    end else if (bus.div_start_s || bus.div_start_u) begin
      dm_res    = div_model(bus.div_dividend, bus.div_divisor, bus.div_start_s);
      dm_q     <= dm_res[31:0];
      dm_r     <= dm_res[63:32];
      dm_cnt   <= 32;
      dm_stall <= 1'b1;
    end else if (dm_cnt != 0) begin
      dm_cnt   <= dm_cnt - 1;
      dm_stall <= (dm_cnt != 1);
    end
  end

  assign bus.div_stall     = force_en ? force_stall : dm_stall;
  assign bus.div_quotient  = dm_q;
  assign bus.div_remainder = dm_r;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  task automatic idle_in();
    bus.op_valid = 1'b0;
    bus.op_code  = MC_NONE;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    #3;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'd0 ||
        bus.div_start_s !== 1'b0 || bus.div_start_u !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs stall=%b result=%h start_s=%b start_u=%b, required 0 0 0 0",
               bus.stall, bus.result, bus.div_start_s, bus.div_start_u);
    end
    drive(MC_MFHI, 32'd0, 32'd0);
    #1;
    n_checks++;
    if (bus.result !== 32'd0 || bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mfhi result=%h stall=%b, required 0 0", bus.result, bus.stall);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_in();
    step();
  endtask

  task automatic test_mult_neg();
    drive(MC_MULT, 32'hFFFF_FFFB, 32'd3);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL mult_accept stall=%b, required 0", bus.stall);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.stall !== 1'b1) begin
        n_errors++;
        $display("FAIL mult_dep_stall cycle %0d stall=%b, required 1", c, bus.stall);
      end
      step();
    end
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'hFFFF_FFF1) begin
      n_errors++;
      $display("FAIL mult_mflo stall=%b result=%h, required 0 fffffff1", bus.stall, bus.result);
    end
    step();
    drive(MC_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL mult_mfhi result=%h, required ffffffff", bus.result);
    end
    step();
    idle_in();
    step();
  endtask

  task automatic test_divu();
    drive(MC_DIVU, 32'd100, 32'd7);
    @(negedge clock);
    n_checks++;
    if (bus.div_start_u !== 1'b1 || bus.div_start_s !== 1'b0 || bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL divu_start start_u=%b start_s=%b stall=%b, required 1 0 0",
               bus.div_start_u, bus.div_start_s, bus.stall);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.stall !== 1'b1 || bus.div_start_u !== 1'b0) begin
        n_errors++;
        $display("FAIL divu_wait cycle %0d stall=%b start_u=%b, required 1 0",
                 c, bus.stall, bus.div_start_u);
      end
      step();
    end
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'd14) begin
      n_errors++;
      $display("FAIL divu_lo stall=%b result=%h, required 0 0000000e", bus.stall, bus.result);
    end
    step();
    drive(MC_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd2) begin
      n_errors++;
      $display("FAIL divu_hi result=%h, required 00000002", bus.result);
    end
    step();
    idle_in();
    step();
  endtask

  task automatic test_madd_msub();
    drive(MC_MTHI, 32'd0, 32'd0);
    step();
    drive(MC_MTLO, 32'hFFFF_FFFF, 32'd0);
    step();
    drive(MC_MADDU, 32'd1, 32'd1);
    step();
    drive(MC_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_errors++;
      $display("FAIL maddu_dep_stall stall=%b, required 1", bus.stall);
    end
    step();
    step();
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'd1) begin
      n_errors++;
      $display("FAIL maddu_hi stall=%b result=%h, required 0 00000001", bus.stall, bus.result);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL maddu_lo result=%h, required 00000000", bus.result);
    end
    step();
    drive(MC_MSUBU, 32'd1, 32'd1);
    step();
    idle_in();
    step();
    step();
    drive(MC_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL msubu_hi stall=%b result=%h, required 0 00000000", bus.stall, bus.result);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL msubu_lo result=%h, required ffffffff", bus.result);
    end
    step();
    idle_in();
    step();
  endtask

  task automatic test_mt_mf();
    drive(MC_MTLO, 32'hA5A5_A5A5, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd0 || bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL mtlo_result result=%h stall=%b, required 0 0", bus.result, bus.stall);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'hA5A5_A5A5) begin
      n_errors++;
      $display("FAIL mtlo_mflo stall=%b result=%h, required 0 a5a5a5a5", bus.stall, bus.result);
    end
    step();
    bus.op_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL mf_not_valid result=%h, required 0", bus.result);
    end
    step();
    idle_in();
    step();
  endtask

  task automatic test_back_to_back();
    // Dependent MF right behind a MULTU.
    drive(MC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(MC_MFHI, 32'd0, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.stall !== (c < 3)) begin
        n_errors++;
        $display("FAIL multu_dep cycle %0d stall=%b, required %b", c, bus.stall, (c < 3));
      end
      if (c < 3) step();
    end
    n_checks++;
    if (bus.result !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL multu_hi result=%h, required fffffffe", bus.result);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd1) begin
      n_errors++;
      $display("FAIL multu_lo result=%h, required 00000001", bus.result);
    end
    step();
    // Second multiply presented in cycle 1 must wait for IDLE.
    drive(MC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(MC_MADD, 32'd2, 32'd3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.stall !== (c < 3)) begin
        n_errors++;
        $display("FAIL b2b_stall cycle %0d stall=%b, required %b", c, bus.stall, (c < 3));
      end
      step();
    end
    idle_in();
    step();
    step();
    drive(MC_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL b2b_hi stall=%b result=%h, required 0 fffffffe", bus.stall, bus.result);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd7) begin
      n_errors++;
      $display("FAIL b2b_lo result=%h, required 00000007", bus.result);
    end
    step();
    idle_in();
    step();
  endtask

  task automatic test_reset_mid_div();
    drive(MC_MTHI, 32'h0000_1234, 32'd0);
    step();
    drive(MC_DIV, 32'd1000, 32'd3);
    @(negedge clock);
    n_checks++;
    if (bus.div_start_s !== 1'b1 || bus.div_start_u !== 1'b0) begin
      n_errors++;
      $display("FAIL div_start start_s=%b start_u=%b, required 1 0",
               bus.div_start_s, bus.div_start_u);
    end
    step();
    idle_in();
    for (int c = 1; c <= 8; c++) step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_errors++;
      $display("FAIL div_pending cycle 9 stall=%b, required 1", bus.stall);
    end
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_mid_lo stall=%b result=%h, required 0 0", bus.stall, bus.result);
    end
    bus.op_code = MC_MFHI;
    #1;
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_mid_hi result=%h, required 0", bus.result);
    end
    step();
    reset = 1'b0;
    idle_in();
    force_en    = 1'b1;
    force_stall = 1'b1;
    for (int c = 0; c < 40; c++) begin
      force_stall = ~force_stall;
      step();
    end
    force_en = 1'b0;
    drive(MC_MFHI, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_nocap_hi stall=%b result=%h, required 0 0", bus.stall, bus.result);
    end
    step();
    drive(MC_MFLO, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.result !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_nocap_lo result=%h, required 0", bus.result);
    end
    step();
    idle_in();
    step();
  endtask

  // Random instruction stream against a HI:LO model; starts from HI:LO = 0.
  task automatic test_random();
    logic [63:0] m_hilo;
    m_hilo = 64'd0;
    for (int n = 0; n < 160; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b, exp_res;
      logic [63:0] prod;
      longint      pa, pb;
      int          waited;
      op = 4'($urandom_range(0, 11));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        bus.op_valid = 1'b0;
        bus.op_code  = MC_MFHI;
        @(negedge clock);
        n_checks++;
        if (bus.result !== 32'd0) begin
          n_errors++;
          $display("FAIL rnd_idle_result op %0d result=%h, required 0", n, bus.result);
        end
        step();
      end
      drive(op, a, b);
      waited = 0;
      @(negedge clock);
      while (bus.stall && waited < 64) begin
        step();
        @(negedge clock);
        waited++;
      end
      n_checks++;
      if (bus.stall !== 1'b0) begin
        n_errors++;
        $display("FAIL rnd_accept_timeout op %0d stall=%b, required 0", n, bus.stall);
      end
      exp_res = 32'd0;
      if (op == MC_MFHI) exp_res = m_hilo[63:32];
      if (op == MC_MFLO) exp_res = m_hilo[31:0];
      n_checks++;
      if (bus.result !== exp_res || bus.div_start_s !== (op == MC_DIV) ||
          bus.div_start_u !== (op == MC_DIVU)) begin
        n_errors++;
        $display("FAIL rnd_op %0d code %0d result=%h start_s=%b start_u=%b, required %h %b %b",
                 n, op, bus.result, bus.div_start_s, bus.div_start_u,
                 exp_res, (op == MC_DIV), (op == MC_DIVU));
      end
      if (op == MC_MULT || op == MC_MADD || op == MC_MSUB) begin
        pa   = $signed(a);
        pb   = $signed(b);
        prod = pa * pb;
      end else begin
        prod = {32'd0, a} * {32'd0, b};
      end
      case (op)
        MC_MULT, MC_MULTU: m_hilo = prod;
        MC_MADD, MC_MADDU: m_hilo = m_hilo + prod;
        MC_MSUB, MC_MSUBU: m_hilo = m_hilo - prod;
        MC_DIV:            m_hilo = div_model(a, b, 1'b1);
        MC_DIVU:           m_hilo = div_model(a, b, 1'b0);
        MC_MTHI:           m_hilo[63:32] = a;
        MC_MTLO:           m_hilo[31:0]  = a;
        default:           m_hilo = m_hilo;
      endcase
      step();
    end
    idle_in();
    step();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    force_en    = 1'b0;
    force_stall = 1'b0;
    test_reset();
    test_mult_neg();
    test_divu();
    test_madd_msub();
    test_mt_mf();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_muldiv_hilo
`default_nettype wire
